tm1638_bcd_display: RTL and testbench
=====================================

# tm1638_bcd_display

Downstream consumer of the BCD second/minute counters. Latches eight BCD digits plus decimal points, decodes each digit to 7-segment code, and writes a full frame to a TM1638 LED/key board over its 3-wire serial interface (STB, CLK, DIO) in write-only mode. One frame is sent per `update` request; requests that arrive during a frame are coalesced into one follow-up frame.

## Interface
- CLK_DIV, 4 — clk cycles per half bit-cell of `tm_clk`; legal range 1–255.
- BRIGHTNESS, 7 — 3-bit TM1638 pulse-width setting sent in the display-control command.
- clk  input  1  system clock; every register updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- update  input  1  single-cycle frame request, typically the counter `tick`.
- digits  input  32  eight BCD digits; `[31:28]` = leftmost grid (address 0x00), `[3:0]` = rightmost grid (address 0x0E).
- dp  input  8  decimal-point enables; bit 7 = leftmost grid.
- busy  output  1  high while a frame is in progress.
- tm_stb  output  1  TM1638 strobe, active low.
- tm_clk  output  1  TM1638 serial clock; the device samples on the rising edge.
- tm_dio  output  1  TM1638 data, LSB first; driven only, never tristated.

## Operation
- Reset values: `busy`=0, `tm_stb`=1, `tm_clk`=1, `tm_dio`=1, pending flag=0, state=IDLE.
- Decode is gfedcba with dp on bit 7. Digits 0–9 map to 3F,06,5B,4F,66,6D,7D,07,7F,6F. Values 10–15 map to 40 (dash).
- States:
  - IDLE: on `update`, capture `digits`/`dp` into the shadow register and go to CMD_MODE.
  - CMD_MODE: sends 0x40 (data write, auto-increment).
  - GAP1
  - CMD_DATA: sends 0xC0, then 16 bytes. Even addresses carry segment bytes; odd addresses (LEDs) carry 0x00.
  - GAP2
  - CMD_CTRL: sends 0x88 | BRIGHTNESS.
  - GAP3: returns to IDLE, or restarts at CMD_MODE if the pending flag is set.
- Each command: `tm_stb` falls, CLK_DIV setup cycles, the bytes, CLK_DIV hold cycles, then `tm_stb` rises. The following GAP holds `tm_stb` high for 2·CLK_DIV cycles.
- Bit cell (2·CLK_DIV cycles):
  - `tm_clk` is low for the first CLK_DIV cycles. `tm_dio` changes only on the cycle `tm_clk` falls.
  - `tm_clk` is high for the second CLK_DIV cycles.
  - Bytes are sent LSB first.
- `update` while busy sets the pending flag; multiple requests collapse into one. On restart from GAP3, the shadow register is recaptured and the pending flag clears in the same cycle. If `update` is also high in that cycle, it is absorbed into this restart.
- The shadow register is stable for the whole frame; input changes mid-frame do not affect the frame in flight.
- Reset asserted mid-frame forces all outputs to their reset values immediately and discards the frame and the pending flag.

## Timing
- `update` sampled high in IDLE at edge N: `busy`=1 and `tm_stb`=0 after edge N.
- Command length is (16·n + 4)·CLK_DIV cycles including its gap, where n = bytes in the command.
- Frame length is 316·CLK_DIV cycles (19 bytes, 3 commands). With the default CLK_DIV, that is 1264 cycles from the `update` edge until `busy` falls.
- `busy` falls on the same edge GAP3 completes unless a restart occurs. With a restart, `busy` stays continuously high.
- `tm_clk` idles high; `tm_dio` idles high outside a strobe window.

## Configuration
- `TM1638_BLANK_LEADING_ZERO_EN` defined: working from the leftmost grid, each digit equal to 0 is sent as 0x00 until the first nonzero digit. The rightmost digit is never blanked. The dp bit of a blanked digit is still sent.
- `TM1638_BLANK_LEADING_ZERO_EN` not defined: every digit is decoded as is.

## Test plan
- Reset release, no `update`, 2000 cycles -> `tm_stb`/`tm_clk`/`tm_dio` stay 1 and `busy` stays 0.
- CLK_DIV=4, digits=0x00000059, dp=0 -> bytes observed on rising `tm_clk`:
  - Command 1: 40.
  - Command 2: C0, then 3F,00 repeated for grids 0–5, then 6D,00,6F,00.
  - Command 3: 8F.
  - `busy` high for exactly 1264 cycles.
- Same stimulus with `TM1638_BLANK_LEADING_ZERO_EN`, digits=0x00000059 -> grids 0–5 send 00; grids 6–7 send 6D,6F.
- digits nibble 0xA and dp=0x80 on grid 0 -> first data byte C0 (40|80).
- Three `update` pulses during frame 1, digits changed to 0x00000100 before GAP3 -> exactly one extra frame carrying the new digits. `busy` stays continuously high and falls 2·1264 cycles after the first `update`.
- Reset asserted asynchronously mid-CMD_DATA with a pending request -> outputs return to 1/1/1/0 before the next clk edge. After release, no frame starts without a new `update`.

Source files
------------

// File: rtl/tm1638_bcd_display_if.sv
// ---------------------------------------------------------------------------
// tm1638_bcd_display_if
// Groups the frame-request inputs, the busy flag and the TM1638 3-wire serial
// lines into one bundle.
//   update  - single-cycle frame request (master -> display)
//   digits  - eight BCD digits, [31:28] = leftmost grid (master -> display)
//   dp      - decimal-point enables, bit 7 = leftmost grid (master -> display)
//   busy    - high while a frame is in progress (display -> master)
//   tm_stb  - TM1638 strobe, active low (display -> board)
//   tm_clk  - TM1638 serial clock, sampled by the board on rising edge
//   tm_dio  - TM1638 serial data, LSB first, always driven
// Modports: master (the counter side) and slave (the display driver).
// ---------------------------------------------------------------------------
interface tm1638_bcd_display_if;
  logic        update;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic        busy;
  logic        tm_stb;
  logic        tm_clk;
  logic        tm_dio;

  modport master (
    output update, digits, dp,
    input  busy, tm_stb, tm_clk, tm_dio
  );

  modport slave (
    input  update, digits, dp,
    output busy, tm_stb, tm_clk, tm_dio
  );
endinterface

// File: rtl/tm1638_bcd_display.sv
// ---------------------------------------------------------------------------
// tm1638_bcd_display
// Latches eight BCD digits plus decimal points, decodes them to 7-segment
// (gfedcba, dp on bit 7) and writes a full frame to a TM1638 board: command
// 0x40, then 0xC0 followed by 16 data bytes, then 0x88 | BRIGHTNESS.
// Requests arriving mid-frame collapse into a single follow-up frame.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous reset, active low
//   bus    - tm1638_bcd_display_if.slave (update/digits/dp in,
//            busy/tm_stb/tm_clk/tm_dio out)
// Parameters:
//   CLK_DIV    - clk cycles per half bit-cell of tm_clk (1..255)
//   BRIGHTNESS - 3-bit TM1638 pulse-width setting
// Optional feature macro: TM1638_BLANK_LEADING_ZERO_EN
//   defined     -> leading zero digits (never the rightmost) sent as blank
//   not defined -> every digit decoded as is
// ---------------------------------------------------------------------------
module tm1638_bcd_display #(
  parameter int         CLK_DIV    = 4,
  parameter logic [2:0] BRIGHTNESS = 3'd7
) (
  input logic                    clk,
  input logic                    reset,
  tm1638_bcd_display_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE, CMD_MODE, GAP1, CMD_DATA, GAP2, CMD_CTRL, GAP3
  } state_t;

  typedef enum logic [1:0] {
    SUB_SETUP, SUB_LOW, SUB_HIGH, SUB_HOLD
  } sub_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q;
  sub_t        sub_q;
  logic [7:0]  divCnt_q;
  logic [2:0]  bitIdx_q;
  logic [4:0]  byteIdx_q;
  logic        gapHalf_q;
  logic        pending_q;
  logic [31:0] shadowDigits_q;
  logic [7:0]  shadowDp_q;
  logic        busy_q;
  logic        stb_q;
  logic        clk_q;
  logic        dio_q;

  logic        halfDone;
  logic        lastByte;
  logic        startFrame;
  logic [4:0]  nextIdx;
  logic [2:0]  nextBit;
  logic [3:0]  dataAddr;
  logic [7:0]  txByte;
  logic [6:0]  segRaw [8];
  logic [7:0]  segByte [8];
  logic [7:0]  blankMask;

  function automatic logic [6:0] decodeDigit(input logic [3:0] d);
    case (d)
      4'd0:    decodeDigit = 7'h3F;
      4'd1:    decodeDigit = 7'h06;
      4'd2:    decodeDigit = 7'h5B;
      4'd3:    decodeDigit = 7'h4F;
      4'd4:    decodeDigit = 7'h66;
      4'd5:    decodeDigit = 7'h6D;
      4'd6:    decodeDigit = 7'h7D;
      4'd7:    decodeDigit = 7'h07;
      4'd8:    decodeDigit = 7'h7F;
      4'd9:    decodeDigit = 7'h6F;
      default: decodeDigit = 7'h40;
    endcase
  endfunction

  assign halfDone = (divCnt_q == DIV_LAST);
  assign lastByte = (state_q == CMD_DATA) ? (byteIdx_q == 5'd16) : 1'b1;

  // A new frame starts from GAP3 if anything asked for one during this frame,
  // including a request landing on the very last GAP3 cycle.
  assign startFrame = pending_q | bus.update;

  // Decode every latched digit; grid 0 is the leftmost one.
  always_comb begin
    for (int g = 0; g < 8; g++) begin
      segRaw[g] = decodeDigit(shadowDigits_q[31-4*g -: 4]);
    end
  end

`ifdef TM1638_BLANK_LEADING_ZERO_EN
  // Walk from the leftmost grid and blank zeros until the first nonzero
  // digit; the rightmost grid is always shown.
  always_comb begin
    logic stillZero;
    stillZero = 1'b1;
    blankMask = 8'h00;
    for (int g = 0; g < 7; g++) begin
      stillZero    = stillZero & (shadowDigits_q[31-4*g -: 4] == 4'd0);
      blankMask[g] = stillZero;
    end
  end
`else
  assign blankMask = 8'h00;
`endif

  // Final segment byte per grid; the dp bit survives blanking.
  always_comb begin
    for (int g = 0; g < 8; g++) begin
      segByte[g] = {shadowDp_q[7-g], blankMask[g] ? 7'h00 : segRaw[g]};
    end
  end

  // Work out which byte and bit go out at the next tm_clk falling edge.
  // Data addresses start after the 0xC0 address byte; odd addresses are the
  // LED positions and always carry zero.
  always_comb begin
    nextIdx = byteIdx_q;
    if (sub_q == SUB_HIGH && bitIdx_q == 3'd7) begin
      nextIdx = byteIdx_q + 5'd1;
    end
    nextBit  = (sub_q == SUB_SETUP) ? 3'd0 : bitIdx_q + 3'd1;
    dataAddr = 4'(nextIdx - 5'd1);
    txByte   = 8'hFF;
    case (state_q)
      CMD_MODE: txByte = 8'h40;
      CMD_DATA: begin
        if (nextIdx == 5'd0) begin
          txByte = 8'hC0;
        end else if (dataAddr[0]) begin
          txByte = 8'h00;
        end else begin
          txByte = segByte[dataAddr[3:1]];
        end
      end
      CMD_CTRL: txByte = {5'b10001, BRIGHTNESS};
      default:  txByte = 8'hFF;
    endcase
  end

  // Main sequencer. Every command runs SETUP (stb low, clk high), eight bit
  // cells per byte (clk low then high, dio changing only as clk falls), and
  // HOLD, each half lasting CLK_DIV cycles; each GAP is two halves with the
  // strobe high. All serial outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      sub_q          <= SUB_SETUP;
      divCnt_q       <= 8'd0;
      bitIdx_q       <= 3'd0;
      byteIdx_q      <= 5'd0;
      gapHalf_q      <= 1'b0;
      pending_q      <= 1'b0;
      shadowDigits_q <= 32'd0;
      shadowDp_q     <= 8'd0;
      busy_q         <= 1'b0;
      stb_q          <= 1'b1;
      clk_q          <= 1'b1;
      dio_q          <= 1'b1;
    end else begin
      if (state_q != IDLE) begin
        divCnt_q <= halfDone ? 8'd0 : divCnt_q + 8'd1;
        if (bus.update) begin
          pending_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.update) begin
            shadowDigits_q <= bus.digits;
            shadowDp_q     <= bus.dp;
            busy_q         <= 1'b1;
            stb_q          <= 1'b0;
            sub_q          <= SUB_SETUP;
            bitIdx_q       <= 3'd0;
            byteIdx_q      <= 5'd0;
            state_q        <= CMD_MODE;
          end
        end

        CMD_MODE, CMD_DATA, CMD_CTRL: begin
          if (halfDone) begin
            case (sub_q)
              SUB_SETUP, SUB_HIGH: begin
                if (sub_q == SUB_HIGH && bitIdx_q == 3'd7 && lastByte) begin
                  sub_q <= SUB_HOLD;
                end else begin
                  sub_q     <= SUB_LOW;
                  clk_q     <= 1'b0;
                  dio_q     <= txByte[nextBit];
                  bitIdx_q  <= nextBit;
                  byteIdx_q <= nextIdx;
                end
              end
              SUB_LOW: begin
                sub_q <= SUB_HIGH;
                clk_q <= 1'b1;
              end
              default: begin
                stb_q     <= 1'b1;
                dio_q     <= 1'b1;
                gapHalf_q <= 1'b0;
                case (state_q)
                  CMD_MODE: state_q <= GAP1;
                  CMD_DATA: state_q <= GAP2;
                  default:  state_q <= GAP3;
                endcase
              end
            endcase
          end
        end

        default: begin
          if (halfDone) begin
            if (!gapHalf_q) begin
              gapHalf_q <= 1'b1;
            end else begin
              gapHalf_q <= 1'b0;
              sub_q     <= SUB_SETUP;
              bitIdx_q  <= 3'd0;
              byteIdx_q <= 5'd0;
              case (state_q)
                GAP1: begin
                  stb_q   <= 1'b0;
                  state_q <= CMD_DATA;
                end
                GAP2: begin
                  stb_q   <= 1'b0;
                  state_q <= CMD_CTRL;
                end
                default: begin
                  if (startFrame) begin
                    shadowDigits_q <= bus.digits;
                    shadowDp_q     <= bus.dp;
                    pending_q      <= 1'b0;
                    stb_q          <= 1'b0;
                    state_q        <= CMD_MODE;
                  end else begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.tm_stb = stb_q;
  assign bus.tm_clk = clk_q;
  assign bus.tm_dio = dio_q;

endmodule

// File: tb/tb_tm1638_bcd_display.sv
// ---------------------------------------------------------------------------
// tb_tm1638_bcd_display
// Drives frame requests into tm1638_bcd_display, decodes the serial stream
// on rising tm_clk and compares every received byte with a queue of expected
// bytes built from the digit/dp values at request time.
// ---------------------------------------------------------------------------
module tb_tm1638_bcd_display;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [7:0] expQ [$];
  logic       monEn;
  logic       tmClkPrev;
  logic [7:0] rxByte;
  int         bitCnt;
  int         busyLen;
  int         viol;

  tm1638_bcd_display_if bus ();

  tm1638_bcd_display #(
    .CLK_DIV   (4),
    .BRIGHTNESS(3'd7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] segOf(input logic [3:0] d);
    case (d)
      4'd0: segOf = 8'h3F;  4'd1: segOf = 8'h06;
      4'd2: segOf = 8'h5B;  4'd3: segOf = 8'h4F;
      4'd4: segOf = 8'h66;  4'd5: segOf = 8'h6D;
      4'd6: segOf = 8'h7D;  4'd7: segOf = 8'h07;
      4'd8: segOf = 8'h7F;  4'd9: segOf = 8'h6F;
      default: segOf = 8'h40;
    endcase
  endfunction

  // Build the 19 expected bytes of one frame and append them to the queue.
  task automatic pushFrame(input logic [31:0] digits, input logic [7:0] dp);
    logic [7:0] b;
    logic [3:0] nib;
    logic       zeroRun;
    zeroRun = 1'b1;
    expQ.push_back(8'h40);
    expQ.push_back(8'hC0);
    for (int g = 0; g < 8; g++) begin
      nib = digits[31-4*g -: 4];
      b   = segOf(nib);
`ifdef TM1638_BLANK_LEADING_ZERO_EN
      if (g < 7 && zeroRun && nib == 4'd0) b = 8'h00;
      else zeroRun = 1'b0;
`endif
      b[7] = dp[7-g];
      expQ.push_back(b);
      expQ.push_back(8'h00);
    end
    expQ.push_back(8'h8F);
    if (zeroRun) zeroRun = 1'b0;
  endtask

  // Present digits/dp with a one-cycle update pulse, optionally recording
  // the frame it should produce. Returns on the negedge after the pulse.
  task automatic applyStimulus(input logic [31:0] digits, input logic [7:0] dp,
                               input bit record);
    @(negedge clk);
    bus.digits = digits;
    bus.dp     = dp;
    bus.update = 1'b1;
    if (record) pushFrame(digits, dp);
    @(negedge clk);
    bus.update = 1'b0;
  endtask

  // Count sampled cycles with busy high, bounded so a stuck DUT still ends.
  task automatic measureBusy(output int len);
    len = 0;
    while (bus.busy === 1'b1 && len < 6000) begin
      len++;
      @(negedge clk);
    end
  endtask

  // Serial decoder: shift dio in on each rising tm_clk inside a strobe
  // window and score every completed byte against the expected queue.
  always @(negedge clk) begin
    if (!reset || !monEn || bus.tm_stb) begin
      bitCnt = 0;
    end else if (!tmClkPrev && bus.tm_clk) begin
      rxByte = {bus.tm_dio, rxByte[7:1]};
      bitCnt++;
      if (bitCnt == 8) begin
        bitCnt = 0;
        if (expQ.size() == 0) begin
          checkOutput("byte_unexpected", {24'd0, rxByte}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("frame_byte", {24'd0, rxByte}, {24'd0, expQ.pop_front()});
        end
      end
    end
    tmClkPrev = bus.tm_clk;
  end

  // Test sequence: reset/idle, single frames, coalesced requests, mid-frame
  // reset.
  initial begin
    checks     = 0;
    failures   = 0;
    monEn      = 1'b1;
    tmClkPrev  = 1'b1;
    rxByte     = 8'h00;
    bitCnt     = 0;
    reset      = 1'b0;
    bus.update = 1'b0;
    bus.digits = 32'd0;
    bus.dp     = 8'd0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, bus.busy},   32'd0);
    checkOutput("rst_stb",  {31'd0, bus.tm_stb}, 32'd1);
    checkOutput("rst_clk",  {31'd0, bus.tm_clk}, 32'd1);
    checkOutput("rst_dio",  {31'd0, bus.tm_dio}, 32'd1);
    reset = 1'b1;

    viol = 0;
    repeat (2000) begin
      @(negedge clk);
      if (bus.tm_stb !== 1'b1 || bus.tm_clk !== 1'b1 || bus.tm_dio !== 1'b1 ||
          bus.busy !== 1'b0) viol++;
    end
    checkOutput("idle_quiet", viol, 0);

    applyStimulus(32'h0000_0059, 8'h00, 1'b1);
    measureBusy(busyLen);
    checkOutput("busy_len_0059", busyLen, 1264);
    repeat (20) @(negedge clk);
    checkOutput("queue_drained_0059", expQ.size(), 0);

    applyStimulus(32'hA000_0123, 8'h80, 1'b1);
    measureBusy(busyLen);
    checkOutput("busy_len_dash", busyLen, 1264);
    repeat (20) @(negedge clk);
    checkOutput("queue_drained_dash", expQ.size(), 0);

    applyStimulus(32'h0000_1234, 8'h05, 1'b1);
    fork
      measureBusy(busyLen);
      begin
        for (int k = 0; k < 3; k++) begin
          repeat (150) @(negedge clk);
          bus.update = 1'b1;
          @(negedge clk);
          bus.update = 1'b0;
        end
        repeat (300) @(negedge clk);
        bus.digits = 32'h0000_0100;
        bus.dp     = 8'h00;
        pushFrame(32'h0000_0100, 8'h00);
      end
    join
    checkOutput("busy_len_coalesced", busyLen, 2 * 1264);
    repeat (20) @(negedge clk);
    checkOutput("queue_drained_coalesced", expQ.size(), 0);

    monEn = 1'b0;
    applyStimulus(32'h0000_0777, 8'h00, 1'b0);
    repeat (200) @(negedge clk);
    bus.update = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
    repeat (50) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst_busy", {31'd0, bus.busy},   32'd0);
    checkOutput("async_rst_stb",  {31'd0, bus.tm_stb}, 32'd1);
    checkOutput("async_rst_clk",  {31'd0, bus.tm_clk}, 32'd1);
    checkOutput("async_rst_dio",  {31'd0, bus.tm_dio}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    viol = 0;
    repeat (2000) begin
      @(negedge clk);
      if (bus.tm_stb !== 1'b1 || bus.busy !== 1'b0) viol++;
    end
    checkOutput("post_rst_no_frame", viol, 0);
    monEn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
